// File: rtl/fs304_pkg.sv
// fs304_pkg: shared state encoding, address constants and bank decode for the FS304 controller
package fs304_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, QUAL} state_e;
  localparam logic [3:0] REG_BASE = 4'h5;
  localparam logic [2:0] RAM_WIN  = 3'h3;
  // The mode rows are wider than six bits; only A20..A15 (the low six bits) reach the pins.
  function automatic logic [5:0] fs304_bank(input logic [3:0] r0, input logic [3:0] r1,
                                            input logic [3:0] r2, input logic [3:0] r3);
    return r3[2] ? (r3[0] ? {r2[1:0], r0} : {r2[0], r0[3:1], 1'b0, r1[1]})
                 : (r3[0] ? {r2[1:0], r0[3:2], 2'b00} : {r2[1:0], r0[3:2], r1[1], 1'b0});
  endfunction
endpackage

// File: rtl/fs304_m2_sync.sv
// fs304_m2_sync: brings raw m2 into the clk domain and flags its rising and falling edges
module fs304_m2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic m2_i,
  output logic m2s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], m2_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign m2s_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = m2s_o & ~prev_q;
  assign fall_o = ~m2s_o & prev_q;
endmodule

// File: rtl/fs304_sync_ctrl.sv
// fs304_sync_ctrl: qualifies M2 bus cycles, commits $5xxx writes to bank registers, drives PRG/WRAM strobes
module fs304_sync_ctrl
  import fs304_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 3,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m2_i,
  input  logic        cpu_rw_i,
  input  logic [7:0]  cpu_data_i,
  input  logic [15:0] cpu_addr_i,
  output logic [5:0]  prg_addr_o,
  output logic        prg_oe_o,
  output logic        ram_ce_o,
  output logic        ram_oe_o,
  output logic        ram_we_o,
  output logic        cyc_err_o
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m2s, rise, fall;
  logic             cap, commit, err_d;
  logic [3:0]       sh_hi_q, sh_data_q;
  logic [1:0]       sh_sel_q;
  logic             sh_rw_q;
  logic [3:0]       reg_q [4];
  logic             commit_q;
  logic [5:0]       prg_addr_q;
  logic             cyc_err_q;
  logic             ram_win;
  logic             unused_bits;

  fs304_m2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .m2_i   (m2_i),
    .m2s_o  (m2s),
    .rise_o (rise),
    .fall_o (fall)
  );

  // FSM state and high-time counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: a cycle qualifies once synced m2 has been high MIN_HIGH clks
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (rise) begin
        state_d = HIGH;
        cnt_d   = CNT_W'(1);
      end
      HIGH: if (fall) begin
        state_d = IDLE;
      end else if (m2s) begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q >= CNT_W'(MIN_HIGH - 1)) state_d = QUAL;
      end
      QUAL: if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: capture also on the entry clk so a minimum-length cycle still has a shadow
  always_comb begin
    cap    = state_d == QUAL;
    commit = state_q == QUAL && fall && !sh_rw_q && sh_hi_q == REG_BASE;
    err_d  = state_q == HIGH && fall;
  end

  // shadow capture, register file commit and the registered bank output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_hi_q    <= '0;
      sh_data_q  <= '0;
      sh_sel_q   <= '0;
      sh_rw_q    <= 1'b1;
      reg_q      <= '{default: 4'h0};
      commit_q   <= 1'b0;
      prg_addr_q <= 6'h00;
      cyc_err_q  <= 1'b0;
    end else begin
      if (cap) begin
        sh_hi_q   <= cpu_addr_i[15:12];
        sh_sel_q  <= cpu_addr_i[9:8];
        sh_data_q <= cpu_data_i[3:0];
        sh_rw_q   <= cpu_rw_i;
      end
      if (commit) reg_q[sh_sel_q] <= sh_data_q;
      commit_q  <= commit;
      cyc_err_q <= err_d;
      if (commit_q) prg_addr_q <= fs304_bank(reg_q[0], reg_q[1], reg_q[2], reg_q[3]);
    end
  end

  // chip strobes follow raw m2 so their timing never depends on clk
  always_comb begin
    ram_win  = cpu_addr_i[15:13] == RAM_WIN;
    prg_oe_o = ~(m2_i & cpu_rw_i & cpu_addr_i[15]);
    ram_ce_o = ~(m2_i & ram_win);
    ram_oe_o = ~(m2_i & ram_win & cpu_rw_i);
    ram_we_o = ~(m2_i & ram_win & ~cpu_rw_i);
  end

  assign prg_addr_o  = prg_addr_q;
  assign cyc_err_o   = cyc_err_q;
  assign unused_bits = ^{cpu_data_i[7:4], cpu_addr_i[11:10], cpu_addr_i[7:0]};
endmodule

// File: tb/tb_fs304_sync_ctrl.sv
// tb_fs304_sync_ctrl: randomized self-checking bench with a behavioural bank/strobe model
module tb_fs304_sync_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_data = 8'h00;
  logic [15:0] cpu_addr = 16'h0000;
  logic [5:0]  prg_addr;
  logic        prg_oe, ram_ce, ram_oe, ram_we, cyc_err;
  int          checks = 0;
  int          errors = 0;
  int          err_pulses = 0;
  int          mr [4] = '{0, 0, 0, 0};

  fs304_sync_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .m2_i       (m2),
    .cpu_rw_i   (cpu_rw),
    .cpu_data_i (cpu_data),
    .cpu_addr_i (cpu_addr),
    .prg_addr_o (prg_addr),
    .prg_oe_o   (prg_oe),
    .ram_ce_o   (ram_ce),
    .ram_oe_o   (ram_oe),
    .ram_we_o   (ram_we),
    .cyc_err_o  (cyc_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cyc_err === 1'b1) err_pulses++;

  // bank value from the mode table, built with plain arithmetic and cut to six address lines
  function automatic logic [5:0] mbank();
    int b;
    case (mr[3] % 8)
      0, 2:    b = mr[2] * 16 + (mr[0] / 4) * 4 + ((mr[1] / 2) % 2) * 2;
      1, 3:    b = mr[2] * 16 + (mr[0] / 4) * 4;
      4, 6:    b = mr[2] * 32 + (mr[0] / 2) * 4 + (mr[1] / 2) % 2;
      default: b = mr[2] * 16 + mr[0];
    endcase
    return 6'(b % 64);
  endfunction

  // expected {prg_oe, ram_ce, ram_oe, ram_we}
  function automatic logic [3:0] mstrobe(input logic [15:0] a, input logic rw, input logic hi);
    logic ram;
    ram = hi && a >= 16'h6000 && a < 16'h8000;
    return {!(hi && rw && a >= 16'h8000), !ram, !(ram && rw), !(ram && !rw)};
  endfunction

  // one bus cycle starting at a negedge; m2 high for hi clks then low for lo clks
  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rw, input int hi, input int lo);
    logic [3:0] obs;
    cpu_addr = a;
    cpu_data = d;
    cpu_rw   = rw;
    m2       = 1'b1;
    #1 obs = {prg_oe, ram_ce, ram_oe, ram_we};
    checks++;
    if (obs !== mstrobe(a, rw, 1'b1)) begin
      errors++;
      $display("FAIL strobe_m2_high addr=%h rw=%b actual=%b expected=%b", a, rw, obs, mstrobe(a, rw, 1'b1));
    end
    repeat (hi) @(negedge clk);
    m2 = 1'b0;
    #1 obs = {prg_oe, ram_ce, ram_oe, ram_we};
    checks++;
    if (obs !== 4'b1111) begin
      errors++;
      $display("FAIL strobe_m2_low addr=%h actual=%b expected=1111", a, obs);
    end
    repeat (lo) @(negedge clk);
    if (hi >= 3 && !rw && a[15:12] == 4'h5) mr[a[9:8]] = int'(d[3:0]);
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpu_addr = 16'h8000;
    cpu_rw   = 1'b1;
    m2       = 1'b1;
    #1;
    checks++;
    if (prg_addr !== 6'h00 || cyc_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs prg_addr=%h cyc_err=%b expected 00/0", prg_addr, cyc_err);
    end
    checks++;
    if (prg_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe prg_oe=%b expected 0", prg_oe);
    end
    m2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_writes();
    bus(16'h5200, 8'h0A, 1'b0, 6, 4);
    checks++;
    if (prg_addr !== mbank()) begin
      errors++;
      $display("FAIL write_reg2 prg_addr=%h expected=%h", prg_addr, mbank());
    end
    bus(16'h5300, 8'h05, 1'b0, 6, 4);
    checks++;
    if (prg_addr !== mbank()) begin
      errors++;
      $display("FAIL write_reg3 prg_addr=%h expected=%h", prg_addr, mbank());
    end
  endtask

  task automatic test_mode_decode();
    logic [5:0] old;
    old = mbank();
    bus(16'h5000, 8'h0C, 1'b0, 6, 3);
    checks++;
    if (prg_addr !== old) begin
      errors++;
      $display("FAIL latency_early prg_addr=%h expected=%h", prg_addr, old);
    end
    @(negedge clk);
    checks++;
    if (prg_addr !== mbank()) begin
      errors++;
      $display("FAIL latency_load prg_addr=%h expected=%h", prg_addr, mbank());
    end
    bus(16'h5100, 8'h02, 1'b0, 6, 4);
    bus(16'h5300, 8'h00, 1'b0, 6, 4);
    checks++;
    if (prg_addr !== 6'h2E || prg_addr !== mbank()) begin
      errors++;
      $display("FAIL mode0_decode prg_addr=%h expected=2e", prg_addr);
    end
  endtask

  task automatic test_short_pulse();
    int e0;
    logic [5:0] old;
    e0  = err_pulses;
    old = prg_addr;
    bus(16'h5000, 8'h07, 1'b0, 2, 5);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL short_pulse_err pulses=%0d expected=%0d", err_pulses - e0, 1);
    end
    checks++;
    if (prg_addr !== old) begin
      errors++;
      $display("FAIL short_pulse_prg prg_addr=%h expected=%h", prg_addr, old);
    end
    #1 m2 = 1'b1;
    #2 m2 = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (err_pulses !== e0 + 1 || prg_addr !== old) begin
      errors++;
      $display("FAIL glitch pulses=%0d prg_addr=%h expected 1/%h", err_pulses - e0, prg_addr, old);
    end
    bus(16'h5100, 8'h02, 1'b0, 4, 4);
    checks++;
    if (prg_addr !== mbank()) begin
      errors++;
      $display("FAIL short_pulse_reg0 prg_addr=%h expected=%h", prg_addr, mbank());
    end
  endtask

  task automatic test_ignored();
    logic [15:0] addrs [6] = '{16'h4200, 16'h6200, 16'h6200, 16'h8000, 16'hC123, 16'h7FFF};
    logic        rws   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [5:0]  old;
    old = prg_addr;
    for (int i = 0; i < 6; i++) begin
      bus(addrs[i], 8'($urandom_range(0, 255)), rws[i], 4, 4);
      checks++;
      if (prg_addr !== old || prg_addr !== mbank()) begin
        errors++;
        $display("FAIL ignored_write addr=%h prg_addr=%h expected=%h", addrs[i], prg_addr, old);
      end
    end
  endtask

  task automatic test_reset_mid_qual();
    cpu_addr = 16'h5000;
    cpu_data = 8'h05;
    cpu_rw   = 1'b0;
    m2       = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (prg_addr !== 6'h00 || cyc_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_qual prg_addr=%h cyc_err=%b expected 00/0", prg_addr, cyc_err);
    end
    m2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mr  = '{0, 0, 0, 0};
    repeat (2) @(negedge clk);
    bus(16'h5200, 8'h03, 1'b0, 4, 4);
    bus(16'h5300, 8'h05, 1'b0, 4, 4);
    checks++;
    if (prg_addr !== mbank()) begin
      errors++;
      $display("FAIL reset_regfile prg_addr=%h expected=%h", prg_addr, mbank());
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    int bad;
    logic [15:0] a;
    logic        rw;
    e0  = err_pulses;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      a  = 16'h5000 | 16'($urandom_range(0, 16'h0FFF));
      rw = ($urandom_range(0, 3) == 0);
      bus(a, 8'($urandom_range(0, 255)), rw, 4, 4);
      checks++;
      if (prg_addr !== mbank()) begin
        errors++;
        bad++;
        if (bad < 8) $display("FAIL b2b_bank cycle=%0d addr=%h prg_addr=%h expected=%h", i, a, prg_addr, mbank());
      end
    end
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL b2b_cyc_err pulses=%0d expected=0", err_pulses - e0);
    end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_mode_decode();
    test_short_pulse();
    test_ignored();
    test_reset_mid_qual();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
